// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall, bubble and flush generation for the
// 5-stage core, with saturating stall-cycle and taken-branch counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             escreg_ex,
    input  logic             lw_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mem_wait,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t nextState;
    logic   loadUse;
    logic   dMiss;
    logic   runRules;
    logic   branchAccept;
    logic   rs1Hit;
    logic   rs2Hit;

    assign rs1Hit  = uses_rs1_id && (rs1_id == rd_ex);
    assign rs2Hit  = uses_rs2_id && (rs2_id == rd_ex);
    assign loadUse = lw_ex && !escreg_ex && (rd_ex != 5'd0)
                     && (rs1Hit || rs2Hit);
    assign dMiss   = dmem_req && !dmem_ready;

    // Same-cycle control decode and next-state selection.
    always_comb begin
        nextState    = state;
        runRules     = 1'b0;
        branchAccept = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        bubble_ex    = 1'b0;
        bubble_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        mem_wait     = 1'b0;
        if (reset) begin
            nextState = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (dMiss) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        bubble_wb    = 1'b1;
                        nextState    = MEM_WAIT;
                    end else begin
                        runRules = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    mem_wait = 1'b1;
                    if (!dmem_ready) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        bubble_wb    = 1'b1;
                    end else begin
                        runRules  = 1'b1;
                        nextState = RUN;
                    end
                end
                FLUSH: begin
                    flush_if_id = 1'b1;
                    stall_pc    = !(imem_ready && !dMiss);
                    if (dMiss) begin
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        bubble_wb    = 1'b1;
                    end else if (imem_ready) begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = RUN;
                end
            endcase
            // Shared rules once no data miss is holding the pipe.
            if (runRules) begin
                if (branch_taken_ex) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    branchAccept = 1'b1;
                    nextState    = imem_ready ? RUN : FLUSH;
                end else if (loadUse || !imem_ready) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end
            end
        end
    end

    // State register and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= nextState;
            if (stall_pc && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branchAccept && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// Control vector order: pc,ifid,idex,exmem,bex,bwb,fifid,fidex,mw.
module tb_hazard_unit;

    localparam int W = 4;

    localparam logic [8:0] C_ZERO  = 9'b000000000;
    localparam logic [8:0] C_LU    = 9'b110010000;
    localparam logic [8:0] C_FRZ   = 9'b111101000;
    localparam logic [8:0] C_FRZMW = 9'b111101001;
    localparam logic [8:0] C_REL   = 9'b000000001;
    localparam logic [8:0] C_FPAIR = 9'b000000110;
    localparam logic [8:0] C_FPMW  = 9'b000000111;
    localparam logic [8:0] C_FHOLD = 9'b100000100;
    localparam logic [8:0] C_FEXIT = 9'b000000100;
    localparam logic [8:0] C_FDMS  = 9'b101101100;

    logic         clk;
    logic         reset;
    logic [4:0]   rs1_id;
    logic [4:0]   rs2_id;
    logic         uses_rs1_id;
    logic         uses_rs2_id;
    logic [4:0]   rd_ex;
    logic         escreg_ex;
    logic         lw_ex;
    logic         branch_taken_ex;
    logic         dmem_req;
    logic         dmem_ready;
    logic         imem_ready;
    logic         stall_pc;
    logic         stall_if_id;
    logic         stall_id_ex;
    logic         stall_ex_mem;
    logic         bubble_ex;
    logic         bubble_wb;
    logic         flush_if_id;
    logic         flush_id_ex;
    logic         mem_wait;
    logic [W-1:0] stall_cycles;
    logic [W-1:0] flush_count;
    logic [8:0]   ctl;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.CNT_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .rs1_id(rs1_id),
        .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id),
        .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex),
        .escreg_ex(escreg_ex),
        .lw_ex(lw_ex),
        .branch_taken_ex(branch_taken_ex),
        .dmem_req(dmem_req),
        .dmem_ready(dmem_ready),
        .imem_ready(imem_ready),
        .stall_pc(stall_pc),
        .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem),
        .bubble_ex(bubble_ex),
        .bubble_wb(bubble_wb),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .mem_wait(mem_wait),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  bubble_ex, bubble_wb, flush_if_id, flush_id_ex,
                  mem_wait};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset           = 1'b0;
        rs1_id          = 5'd0;
        rs2_id          = 5'd0;
        uses_rs1_id     = 1'b0;
        uses_rs2_id     = 1'b0;
        rd_ex           = 5'd0;
        escreg_ex       = 1'b1;
        lw_ex           = 1'b0;
        branch_taken_ex = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b1;
        imem_ready      = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset gates every control even with hazards present.
        idle();
        reset = 1'b1;
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        branch_taken_ex = 1'b1;
        #1;
        chk("rst_ctl", 16'(ctl), 16'(C_ZERO));
        tick();
        chk("rst_stall_cnt", 16'(stall_cycles), 16'd0);
        chk("rst_flush_cnt", 16'(flush_count), 16'd0);
        idle();
        #1;
        chk("rst_run_idle", 16'(ctl), 16'(C_ZERO));

        // Load-use via rs1, then the non-hazard variants, then rs2.
        doReset();
        lw_ex = 1'b1; escreg_ex = 1'b0; rd_ex = 5'd5;
        rs1_id = 5'd5; uses_rs1_id = 1'b1;
        #1; chk("lu_rs1", 16'(ctl), 16'(C_LU));
        tick();
        lw_ex = 1'b0;
        #1; chk("lu_after_bubble", 16'(ctl), 16'(C_ZERO));
        tick();
        lw_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
        #1; chk("lu_rd0", 16'(ctl), 16'(C_ZERO));
        tick();
        rd_ex = 5'd5; rs1_id = 5'd5; escreg_ex = 1'b1;
        #1; chk("lu_nowrite", 16'(ctl), 16'(C_ZERO));
        tick();
        escreg_ex = 1'b0; uses_rs1_id = 1'b0;
        #1; chk("lu_rs1_unused", 16'(ctl), 16'(C_ZERO));
        tick();
        uses_rs2_id = 1'b1; rs2_id = 5'd5;
        #1; chk("lu_rs2", 16'(ctl), 16'(C_LU));
        tick();
        idle();
        #1; chk("lu_stall_cnt", 16'(stall_cycles), 16'd2);

        // Load-use together with an I-miss: one stall, one bubble.
        doReset();
        lw_ex = 1'b1; escreg_ex = 1'b0; rd_ex = 5'd7;
        rs2_id = 5'd7; uses_rs2_id = 1'b1; imem_ready = 1'b0;
        #1; chk("lu_imiss", 16'(ctl), 16'(C_LU));
        tick();

        // D-miss for 4 cycles then release.
        doReset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("dm_c1", 16'(ctl), 16'(C_FRZ));
        tick();
        for (int i = 2; i <= 4; i++) begin
            #1; chk($sformatf("dm_c%0d", i), 16'(ctl), 16'(C_FRZMW));
            tick();
        end
        dmem_ready = 1'b1;
        #1; chk("dm_release", 16'(ctl), 16'(C_REL));
        tick();
        idle();
        #1; chk("dm_back_run", 16'(ctl), 16'(C_ZERO));
        chk("dm_stall_cnt", 16'(stall_cycles), 16'd4);

        // Taken branch with I-miss for 3 cycles.
        doReset();
        branch_taken_ex = 1'b1; imem_ready = 1'b0;
        #1; chk("br_c0", 16'(ctl), 16'(C_FPAIR));
        tick();
        branch_taken_ex = 1'b0;
        #1; chk("br_c1", 16'(ctl), 16'(C_FHOLD));
        tick();
        #1; chk("br_c2", 16'(ctl), 16'(C_FHOLD));
        tick();
        imem_ready = 1'b1;
        #1; chk("br_exit", 16'(ctl), 16'(C_FEXIT));
        tick();
        #1; chk("br_run", 16'(ctl), 16'(C_ZERO));
        chk("br_flush_cnt", 16'(flush_count), 16'd1);
        chk("br_stall_cnt", 16'(stall_cycles), 16'd2);

        // D-miss while in FLUSH.
        doReset();
        branch_taken_ex = 1'b1; imem_ready = 1'b0;
        tick();
        branch_taken_ex = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("fl_dmiss", 16'(ctl), 16'(C_FDMS));
        tick();
        dmem_ready = 1'b1;
        #1; chk("fl_dmiss_exit", 16'(ctl), 16'(C_FEXIT));
        tick();

        // Simultaneous D-miss and branch: branch deferred to release.
        doReset();
        branch_taken_ex = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("db_c0", 16'(ctl), 16'(C_FRZ));
        tick();
        #1; chk("db_c1", 16'(ctl), 16'(C_FRZMW));
        tick();
        dmem_ready = 1'b1;
        #1; chk("db_release", 16'(ctl), 16'(C_FPMW));
        tick();
        idle();
        #1; chk("db_run", 16'(ctl), 16'(C_ZERO));
        chk("db_flush_cnt", 16'(flush_count), 16'd1);

        // Reset pulse in MEM_WAIT.
        doReset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        #1; chk("rw_in_wait", 16'(ctl), 16'(C_FRZMW));
        reset = 1'b1;
        #1; chk("rw_rst_ctl", 16'(ctl), 16'(C_ZERO));
        tick();
        idle();
        #1; chk("rw_run", 16'(ctl), 16'(C_ZERO));
        chk("rw_stall_cnt", 16'(stall_cycles), 16'd0);

        // Stall counter saturation.
        doReset();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", 16'(stall_cycles), 16'd15);
        tick();
        chk("sat_hold", 16'(stall_cycles), 16'd15);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
